// File: rtl/image_ram_sdp.sv
// Simple-dual-port image frame buffer with configurable read latency,
// defined read/write collision behaviour and a built-in frame clear engine.
module image_ram_sdp #(
  parameter int DATA_W    = 8,
  parameter int IMG_W     = 256,
  parameter int IMG_H     = 256,
  parameter int ADDR_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int COLL_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_val,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int                DEPTH     = IMG_W * IMG_H;
  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_L);
  endfunction

  clr_state_t        state_r;
  clr_state_t        state_nx_s;
  logic [ADDR_W-1:0] ptr_r;
  logic [DATA_W-1:0] clr_val_r;
  logic              wr_ready_r;
  logic              clr_busy_r;
  logic              clr_done_r;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_fire_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [DATA_W-1:0] wr_word_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic              rd_hit_s;
  logic [DATA_W-1:0] rd_word_s;

  logic [RD_LAT-1:0] vld_r;
  logic [DATA_W-1:0] dat_r [RD_LAT];

  // Clear engine next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (clr_start) state_nx_s = ST_CLEAR;
        else           state_nx_s = ST_IDLE;
      end
      ST_CLEAR: begin
        if (ptr_r == LAST_ADDR) state_nx_s = ST_DONE;
        else                    state_nx_s = ST_CLEAR;
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Clear engine state, fill pointer and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ptr_r      <= '0;
      clr_val_r  <= '0;
      wr_ready_r <= 1'b1;
      clr_busy_r <= 1'b0;
      clr_done_r <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      wr_ready_r <= (state_nx_s != ST_CLEAR);
      clr_busy_r <= (state_nx_s == ST_CLEAR);
      clr_done_r <= (state_nx_s == ST_DONE);
      if (state_r == ST_IDLE && clr_start) begin
        ptr_r     <= '0;
        clr_val_r <= clr_val;
      end else if (state_r == ST_CLEAR && ptr_r != LAST_ADDR) begin
        ptr_r <= ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Single write port shared by the clear engine and user writes; they never overlap
  // because user writes are refused while clearing.
  always_comb begin
    wr_fire_s = 1'b0;
    wr_idx_s  = ptr_r[IDX_W-1:0];
    wr_word_s = clr_val_r;
    if (rst) begin
      wr_fire_s = 1'b0;
    end else if (state_r == ST_CLEAR) begin
      wr_fire_s = 1'b1;
    end else if (wr_en && wr_ready_r && in_range(wr_addr)) begin
      wr_fire_s = 1'b1;
      wr_idx_s  = wr_addr[IDX_W-1:0];
      wr_word_s = wr_data;
    end else begin
      wr_fire_s = 1'b0;
    end
  end

  // Read word selection, including write-through bypass on address collision.
  always_comb begin
    rd_idx_s  = rd_addr[IDX_W-1:0];
    rd_hit_s  = wr_fire_s && (wr_idx_s == rd_idx_s);
    rd_word_s = '0;
    if (!in_range(rd_addr)) begin
      rd_word_s = '0;
    end else if ((COLL_MODE != 0) && rd_hit_s) begin
      rd_word_s = wr_word_s;
    end else begin
      rd_word_s = mem[rd_idx_s];
    end
  end

  // Storage array; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_fire_s) mem[wr_idx_s] <= wr_word_s;
  end

  // Read pipeline; data stages only load on a valid beat so the output holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r <= '0;
      for (int i = 0; i < RD_LAT; i++) dat_r[i] <= '0;
    end else begin
      vld_r[0] <= rd_en;
      if (rd_en) dat_r[0] <= rd_word_s;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_r[i] <= vld_r[i-1];
        if (vld_r[i-1]) dat_r[i] <= dat_r[i-1];
      end
    end
  end

  assign rd_valid = vld_r[RD_LAT-1];
  assign rd_data  = dat_r[RD_LAT-1];
  assign wr_ready = wr_ready_r;
  assign clr_busy = clr_busy_r;
  assign clr_done = clr_done_r;

endmodule

// File: tb/tb_image_ram_sdp.sv
// Randomised bench for image_ram_sdp: two instances (256x256/lat1/old-data and
// 100x100/lat3/write-through) share stimulus and are checked against a frame model.
module tb_image_ram_sdp;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic        clr_start;
  logic [7:0]  clr_val;

  logic [7:0]  rd_data_s  [2];
  logic        rd_valid_s [2];
  logic        wr_ready_s [2];
  logic        clr_busy_s [2];
  logic        clr_done_s [2];

  always #5 clk = ~clk;

  image_ram_sdp #(.DATA_W(8), .IMG_W(256), .IMG_H(256), .ADDR_W(16), .RD_LAT(1), .COLL_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready_s[0]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_s[0]),
    .rd_valid(rd_valid_s[0]), .clr_start(clr_start), .clr_val(clr_val),
    .clr_busy(clr_busy_s[0]), .clr_done(clr_done_s[0]));

  image_ram_sdp #(.DATA_W(8), .IMG_W(100), .IMG_H(100), .ADDR_W(16), .RD_LAT(3), .COLL_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready_s[1]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_s[1]),
    .rd_valid(rd_valid_s[1]), .clr_start(clr_start), .clr_val(clr_val),
    .clr_busy(clr_busy_s[1]), .clr_done(clr_done_s[1]));

  // Reference model: a plain array per frame (-1 = never written), clear progress
  // as (phase, words written) and a list of read results due at given edges.
  int    depth_m [2] = '{65536, 10000};
  int    lat_m   [2] = '{1, 3};
  int    coll_m  [2] = '{0, 1};
  string nm      [2] = '{"A", "B"};
  int    mem_m   [2][65536];
  int    phase_m [2];
  int    ptr_m   [2];
  int    cval_m  [2];
  int    last_m  [2];
  int    due_q   [2][$];
  int    dat_q   [2][$];
  int    edge_cnt;
  int    n_checks;
  int    n_pass;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, obs, exp, edge_cnt);
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      phase_m[m] = 0;
      ptr_m[m]   = 0;
      last_m[m]  = 0;
      due_q[m].delete();
      dat_q[m].delete();
    end
  endtask

  task automatic model_edge(input int m);
    int wa;
    int wd;
    int rd;
    wa = -1;
    wd = 0;
    if (phase_m[m] == 1) begin
      wa = ptr_m[m];
      wd = cval_m[m];
    end else if (wr_en && int'(wr_addr) < depth_m[m]) begin
      wa = int'(wr_addr);
      wd = int'(wr_data);
    end
    if (rd_en) begin
      if (int'(rd_addr) >= depth_m[m])               rd = 0;
      else if (coll_m[m] == 1 && wa == int'(rd_addr)) rd = wd;
      else                                            rd = mem_m[m][int'(rd_addr)];
      due_q[m].push_back(edge_cnt + lat_m[m] - 1);
      dat_q[m].push_back(rd);
    end
    if (wa >= 0) mem_m[m][wa] = wd;
    case (phase_m[m])
      0: if (clr_start) begin
        phase_m[m] = 1;
        ptr_m[m]   = 0;
        cval_m[m]  = int'(clr_val);
      end
      1: begin
        ptr_m[m]++;
        if (ptr_m[m] == depth_m[m]) phase_m[m] = 2;
      end
      default: phase_m[m] = 0;
    endcase
  endtask

  task automatic model_compare(input int m);
    int ev;
    int ed;
    if (due_q[m].size() > 0 && due_q[m][0] == edge_cnt) begin
      ev = 1;
      ed = dat_q[m].pop_front();
      void'(due_q[m].pop_front());
      last_m[m] = ed;
    end else begin
      ev = 0;
      ed = last_m[m];
    end
    check_val({nm[m], ".rd_valid"}, 32'(rd_valid_s[m]), ev);
    if (ed >= 0) check_val({nm[m], ".rd_data"}, 32'(rd_data_s[m]), ed);
    check_val({nm[m], ".clr_busy"}, 32'(clr_busy_s[m]), 32'(phase_m[m] == 1));
    check_val({nm[m], ".clr_done"}, 32'(clr_done_s[m]), 32'(phase_m[m] == 2));
    check_val({nm[m], ".wr_ready"}, 32'(wr_ready_s[m]), 32'(phase_m[m] != 1));
  endtask

  task automatic step();
    @(posedge clk);
    edge_cnt++;
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    model_compare(0);
    model_compare(1);
  endtask

  task automatic idle_in();
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    clr_start = 1'b0;
  endtask

  task automatic reset_checks();
    for (int m = 0; m < 2; m++) begin
      check_val({nm[m], ".rst_rd_valid"}, 32'(rd_valid_s[m]), 32'd0);
      check_val({nm[m], ".rst_rd_data"},  32'(rd_data_s[m]),  32'd0);
      check_val({nm[m], ".rst_clr_busy"}, 32'(clr_busy_s[m]), 32'd0);
      check_val({nm[m], ".rst_clr_done"}, 32'(clr_done_s[m]), 32'd0);
    end
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom_range(0, 15));
      1:       return 16'($urandom_range(9990, 10010));
      2:       return 16'($urandom_range(65520, 65535));
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  task automatic do_write(input int a, input int d);
    idle_in();
    wr_en   = 1'b1;
    wr_addr = 16'(a);
    wr_data = 8'(d);
    step();
    idle_in();
  endtask

  task automatic do_read(input int a);
    idle_in();
    rd_en   = 1'b1;
    rd_addr = 16'(a);
    step();
    idle_in();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    edge_cnt = 0;
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 65536; a++) mem_m[m][a] = -1;
    idle_in();
    wr_addr = 16'd0;
    wr_data = 8'd0;
    rd_addr = 16'd0;
    clr_val = 8'd0;
    rst     = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    reset_checks();
    rst = 1'b0;
    #1;
    check_val("A.wr_ready_after_rst", 32'(wr_ready_s[0]), 32'd1);
    check_val("B.wr_ready_after_rst", 32'(wr_ready_s[1]), 32'd1);

    // Single write then read: latency 1 on A, 3 on B.
    do_write(16'h1234, 8'hA5);
    do_read(16'h1234);
    repeat (4) step();

    // Streaming write then back-to-back read of 0..255.
    for (int i = 0; i < 256; i++) do_write(i, i & 8'hFF);
    for (int i = 0; i < 256; i++) do_read(i);
    repeat (4) step();

    // Same-edge write/read collision at address 5.
    do_write(5, 8'h11);
    wr_en = 1'b1; wr_addr = 16'd5; wr_data = 8'h22;
    rd_en = 1'b1; rd_addr = 16'd5;
    step();
    idle_in();
    do_read(5);
    repeat (4) step();

    // Address 10000: last+1 for B, ordinary for A.
    do_write(10000, 8'h5A);
    do_read(10000);
    do_read(9999);
    repeat (4) step();

    // Random traffic concentrated on small, boundary and top addresses.
    for (int i = 0; i < 2000; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      rd_en   = 1'($urandom_range(0, 1));
      wr_addr = rand_addr();
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : rand_addr();
      wr_data = 8'($urandom);
      step();
    end
    idle_in();
    repeat (4) step();

    // Full frame clear; user write on the start edge is accepted then overwritten.
    clr_val   = 8'h7F;
    clr_start = 1'b1;
    wr_en     = 1'b1;
    wr_addr   = 16'd7;
    wr_data   = 8'hC3;
    step();
    for (int c = 0; c < 65540; c++) begin
      clr_start = (c == 5000);
      wr_en     = (c < 9000) ? 1'($urandom_range(0, 1)) : 1'b0;
      wr_addr   = rand_addr();
      wr_data   = 8'($urandom);
      rd_en     = 1'($urandom_range(0, 1));
      rd_addr   = rand_addr();
      step();
    end
    idle_in();
    do_read(0);
    do_read(32768);
    do_read(65535);
    do_read(7);
    repeat (4) step();

    // Reset 100 cycles into a clear, with a read in flight.
    do_write(200, 8'h33);
    do_write(50, 8'h44);
    clr_val   = 8'h7F;
    clr_start = 1'b1;
    step();
    idle_in();
    repeat (99) step();
    do_read(50);
    rst = 1'b1;
    #1;
    reset_checks();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) step();
    do_read(50);
    do_read(200);
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/image_ram_sdp.md
Name: image_ram_sdp

Overview:
- Parametrised simple-dual-port image buffer: one write port, one read port, both usable every cycle.
- Configurable read latency with a valid flag, and a defined read/write collision mode.
- Built-in hardware clear engine fills the whole frame with a constant.
- Sits between the pixel producer (capture/filter stage) and consumer (display/processing stage). Replaces the single-port 8-bit, 256x256 store.

Parameters:
DATA_W, 8, pixel width in bits
IMG_W, 256, image width in pixels
IMG_H, 256, image height in pixels
ADDR_W, 16, address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
RD_LAT, 1, read latency in cycles, legal 1..3
COLL_MODE, 0, same-address same-cycle write+read: 0 = read returns old data, 1 = read returns new (write-through)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
wr_en  in  1  write request
wr_addr  in  ADDR_W  write address (linear, y*IMG_W+x)
wr_data  in  DATA_W  write data
wr_ready  out  1  high when user writes are accepted (low during clear)
rd_en  in  1  read request
rd_addr  in  ADDR_W  read address
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data valid this cycle
clr_start  in  1  start frame clear (sampled when idle)
clr_val  in  DATA_W  fill value, captured with clr_start
clr_busy  out  1  clear in progress
clr_done  out  1  one-cycle pulse when clear completes

Behaviour:
- DEPTH = IMG_W*IMG_H words. Memory contents are not reset and are undefined until written or cleared.
- Reset (asynchronous): rd_valid=0, rd_data=0, all read pipeline stages invalid/0, clr_busy=0, clr_done=0, FSM=IDLE, clear pointer=0, wr_ready=1 after release.
- Write: if wr_en && wr_ready && wr_addr<DEPTH at edge k, mem[wr_addr]=wr_data from edge k on. Out-of-range writes are dropped silently. A wr_en while wr_ready=0 is dropped; nothing is queued.
- Read: rd_en at edge k → rd_data/rd_valid asserted for exactly one cycle after edge k+RD_LAT-1, i.e. RD_LAT edges after sampling. RD_LAT=1 means registered output.
- Back-to-back reads give one result per cycle, in order.
- rd_addr>=DEPTH returns 0 with rd_valid=1.
- rd_data holds its last value while rd_valid=0.
- Reads are accepted at all times, including during clear.
- Collision (write and read same address, same edge): COLL_MODE=0 returns the pre-write word; COLL_MODE=1 returns the word being written. This applies equally to clear-engine writes.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: clr_start=1 → latch clr_val, pointer=0, go to CLEAR. clr_busy=1 and wr_ready=0 from the next cycle.
  - CLEAR: each cycle write clr_val to mem[pointer] and increment pointer. After writing DEPTH-1 go to DONE. Total DEPTH cycles.
  - DONE: one cycle, clr_done=1, clr_busy=0, wr_ready=1, then IDLE.
  - clr_start in CLEAR or DONE is ignored.
  - A user write issued on the same edge clr_start is sampled is accepted, because wr_ready is still 1. It is then overwritten by the clear.
- Reset during CLEAR: clear aborts immediately, no clr_done pulse, memory is partially filled, FSM returns to IDLE.
- Reset during a read: in-flight reads are discarded and no rd_valid is produced.
- Pointer is ADDR_W wide and never wraps past DEPTH-1.

Test Plan:
- Reset, write 0xA5 to addr 0x1234, read 0x1234 with RD_LAT=1 → rd_valid one cycle after rd_en, rd_data=0xA5; repeat with RD_LAT=3 → valid 3 edges after rd_en.
- Streaming: write addr i=i&0xFF for i=0..255, then read 0..255 back-to-back → 256 consecutive rd_valid cycles, data 0x00..0xFF in order.
- Collision: mem[5]=0x11, same edge write 0x22 to 5 and read 5 → COLL_MODE=0 returns 0x11, COLL_MODE=1 returns 0x22; subsequent read returns 0x22.
- Clear: clr_start with clr_val=0x7F → clr_busy high exactly 65536 cycles, then clr_done pulse one cycle. Spot reads at 0, 32768, 65535 return 0x7F. wr_en during busy is dropped (prior value overwritten by 0x7F; post-clear value still 0x7F).
- Reset mid-clear: assert rst after 100 CLEAR cycles → clr_busy=0, rd_valid=0 immediately, no clr_done. Addr 50 reads 0x7F, addr 200 keeps its old value.
- Boundary: IMG_W=100, IMG_H=100 (DEPTH=10000): write to addr 10000 dropped, read of 10000 returns 0 with rd_valid=1. Clear takes 10000 cycles; clr_start during busy does not restart it.
